// File: rtl/fifo_rd_packer_if.sv
// FIFO read port and packed output stream of fifo_rd_packer, bundled as one interface.
// The packer connects through the master modport; the FIFO/sink side uses slave.
interface fifo_rd_packer_if #(
    parameter int WIDTH = 8,
    parameter int LANES = 4
);
    localparam int OUT_WIDTH = WIDTH * LANES;

    logic                 fifo_empty_i;
    logic                 fifo_rd_en_o;
    logic [WIDTH-1:0]     fifo_rdata_i;
    logic                 m_valid_o;
    logic                 m_ready_i;
    logic [OUT_WIDTH-1:0] m_data_o;
    logic [LANES-1:0]     m_keep_o;
    logic                 m_last_o;

    modport master (
        input  fifo_empty_i, fifo_rdata_i, m_ready_i,
        output fifo_rd_en_o, m_valid_o, m_data_o, m_keep_o, m_last_o
    );

    modport slave (
        output fifo_empty_i, fifo_rdata_i, m_ready_i,
        input  fifo_rd_en_o, m_valid_o, m_data_o, m_keep_o, m_last_o
    );
endinterface

// File: rtl/fifo_rd_packer.sv
// Drains a 1-cycle-latency FIFO read port and packs LANES entries per output word;
// flush_i closes a partially filled word with a lane mask and last marker.
module fifo_rd_packer #(
    parameter  int WIDTH     = 8,
    parameter  int LANES     = 4,
    localparam int OUT_WIDTH = WIDTH * LANES
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    fifo_rd_packer_if.master bus
);
    localparam int             CW        = $clog2(LANES + 1);
    localparam logic [CW-1:0]  LAST_LANE = CW'(LANES - 1);
    localparam logic [CW:0]    LANES_C   = (CW + 1)'(LANES);

    typedef enum logic [1:0] {FILL, FLUSH, HOLD} state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic                 inflight;
    logic                 flush_pending;
    logic                 rd_en;
    logic [OUT_WIDTH-1:0] data_q;
    logic [LANES-1:0]     keep_q;
    logic                 valid_q;
    logic                 last_q;

    function automatic logic [LANES-1:0] lane_mask(input logic [CW-1:0] n);
        logic [LANES-1:0] m;
        m = '0;
        for (int i = 0; i < LANES; i++) begin
            if (CW'(i) < n) m[i] = 1'b1;
        end
        return m;
    endfunction

    // Lanes already filled plus the one still in flight bound how far ahead we may read.
    assign rd_en = rst_ni && (state == FILL) && !bus.fifo_empty_i && !flush_pending && !flush_i
                   && (({1'b0, cnt} + {{CW{1'b0}}, inflight}) < LANES_C);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state         <= FILL;
            cnt           <= '0;
            inflight      <= 1'b0;
            flush_pending <= 1'b0;
            data_q        <= '0;
            keep_q        <= '0;
            valid_q       <= 1'b0;
            last_q        <= 1'b0;
        end else begin
            inflight <= rd_en;
            if (inflight) begin
                data_q[WIDTH*int'(cnt) +: WIDTH] <= bus.fifo_rdata_i;
                cnt                              <= cnt + 1'b1;
            end
            case (state)
                FILL: begin
                    if (inflight && cnt == LAST_LANE) begin
                        state         <= HOLD;
                        valid_q       <= 1'b1;
                        keep_q        <= '1;
                        last_q        <= flush_pending | flush_i;
                        flush_pending <= 1'b0;
                    end else if (flush_pending) begin
                        state <= FLUSH;
                    end else if (flush_i) begin
                        flush_pending <= 1'b1;
                    end
                end
                FLUSH: begin
                    // Only resolve once no read is outstanding, so every requested entry lands.
                    if (!inflight) begin
                        flush_pending <= 1'b0;
                        if (cnt != '0) begin
                            state   <= HOLD;
                            valid_q <= 1'b1;
                            keep_q  <= lane_mask(cnt);
                            last_q  <= 1'b1;
                        end else begin
                            state <= FILL;
                        end
                    end
                end
                HOLD: begin
                    if (flush_i) flush_pending <= 1'b1;
                    if (bus.m_ready_i) begin
                        state   <= FILL;
                        valid_q <= 1'b0;
                        cnt     <= '0;
                        data_q  <= '0;
                        keep_q  <= '0;
                        last_q  <= 1'b0;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    assign bus.fifo_rd_en_o = rd_en;
    assign bus.m_valid_o    = valid_q;
    assign bus.m_data_o     = data_q;
    assign bus.m_keep_o     = keep_q;
    assign bus.m_last_o     = last_q;
endmodule
